// File: rtl/card_dealer.sv
// Deals a four-card hand for the 24 game from an external LFSR stream.
// Each draw steps the LFSR once, then range-checks the advanced sample.
module card_dealer #(
  parameter int                DATA_W     = 4,
  parameter logic [DATA_W-1:0] MIN_VAL    = 4'd1,
  parameter logic [DATA_W-1:0] MAX_VAL    = 4'd9,
  parameter int                DRAW_LIMIT = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              deal,
  input  logic [DATA_W-1:0] rand_in,
  output logic              rand_step,
  output logic [DATA_W-1:0] card0,
  output logic [DATA_W-1:0] card1,
  output logic [DATA_W-1:0] card2,
  output logic [DATA_W-1:0] card3,
  output logic              valid,
  output logic              busy
);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] STEP_HI = 2'd1;
  localparam logic [1:0] STEP_LO = 2'd2;

  localparam logic [5:0] LIMIT = DRAW_LIMIT[5:0];

  logic [1:0]        state;
  logic              deal_q;
  logic [1:0]        slot;
  logic [5:0]        draws;
  logic [DATA_W-1:0] card_r [4];

  function automatic logic in_range(input logic [DATA_W-1:0] v);
    return (v >= MIN_VAL) && (v <= MAX_VAL);
  endfunction

  function automatic logic [5:0] sat_inc(input logic [5:0] v);
    return (v == 6'h3f) ? v : v + 6'd1;
  endfunction

  logic req;
  logic take;
  logic [DATA_W-1:0] card_val;

  assign req      = deal && !deal_q;
  // Past the draw limit a rejected sample is replaced rather than retried.
  assign take     = in_range(rand_in) || (draws >= LIMIT);
  assign card_val = in_range(rand_in) ? rand_in : MIN_VAL;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      deal_q    <= 1'b0;
      slot      <= 2'd0;
      draws     <= 6'd0;
      rand_step <= 1'b0;
      valid     <= 1'b0;
      busy      <= 1'b0;
      for (int i = 0; i < 4; i++) card_r[i] <= '0;
    end else begin
      deal_q <= deal;
      case (state)
        IDLE: begin
          if (req) begin
            busy      <= 1'b1;
            valid     <= 1'b0;
            rand_step <= 1'b1;
            slot      <= 2'd0;
            draws     <= 6'd0;
            state     <= STEP_HI;
          end
        end
        STEP_HI: begin
          rand_step <= 1'b0;
          state     <= STEP_LO;
        end
        STEP_LO: begin
          draws <= sat_inc(draws);
          if (take) begin
            card_r[slot] <= card_val;
            slot         <= slot + 2'd1;
          end
          if (take && (slot == 2'd3)) begin
            busy  <= 1'b0;
            valid <= 1'b1;
            state <= IDLE;
          end else begin
            rand_step <= 1'b1;
            state     <= STEP_HI;
          end
        end
        default: begin
          rand_step <= 1'b0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

  assign card0 = card_r[0];
  assign card1 = card_r[1];
  assign card2 = card_r[2];
  assign card3 = card_r[3];

endmodule

// File: tb/tb_card_dealer.sv
// Directed bench for card_dealer with a table-driven stand-in for the LFSR.
module tb_card_dealer;

  logic       clk = 1'b0;
  logic       rst;
  logic       deal;
  logic [3:0] rand_in;
  logic       rand_step;
  logic [3:0] card0, card1, card2, card3;
  logic       valid, busy;

  logic       force_en;
  logic [3:0] force_val;
  int         idx;
  logic       step_q;
  int         pulses;
  logic       overlap;

  int n_checks = 0;
  int n_pass   = 0;

  card_dealer dut (
    .clk(clk), .rst(rst), .deal(deal), .rand_in(rand_in),
    .rand_step(rand_step), .card0(card0), .card1(card1),
    .card2(card2), .card3(card3), .valid(valid), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] lfsr_val(input int i);
    case (i)
      0: return 4'd15;
      1: return 4'd4;   2: return 4'd8;   3: return 4'd0;
      4: return 4'd1;   5: return 4'd3;   6: return 4'd7;
      7: return 4'd14;  8: return 4'd13;  9: return 4'd11;
      10: return 4'd6;  11: return 4'd12; 12: return 4'd9;
      13: return 4'd2;
      default: return 4'd0;
    endcase
  endfunction

  assign rand_in = force_en ? force_val : lfsr_val(idx);

  // LFSR model: advances once per 0->1 transition of rand_step
  initial begin
    idx = 0; step_q = 1'b0; pulses = 0; overlap = 1'b0;
  end
  always @(posedge clk) begin
    step_q <= rand_step;
    if (rand_step && !step_q) begin
      pulses <= pulses + 1;
      if (idx < 14) idx <= idx + 1;
    end
  end
  always @(negedge clk) if (valid && busy) overlap <= 1'b1;

  task automatic chk(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic chk_cards(input string tag, input int a, input int b, input int c, input int d);
    chk({tag, "_c0"}, card0, a);
    chk({tag, "_c1"}, card1, b);
    chk({tag, "_c2"}, card2, c);
    chk({tag, "_c3"}, card3, d);
  endtask

  // Drops deal, raises it, and reports the number of edges after E0 until valid.
  task automatic deal_and_wait(input string tag, output int lat);
    @(negedge clk) deal = 1'b0;
    @(negedge clk) deal = 1'b1;
    @(posedge clk); #1;
    chk({tag, "_busy_e0"}, busy, 1);
    chk({tag, "_step_e0"}, rand_step, 1);
    chk({tag, "_valid_e0"}, valid, 0);
    lat = -1;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk); #1;
      if (valid) begin lat = n; break; end
    end
    if (lat < 0) chk({tag, "_timeout"}, 0, 1);
  endtask

  int lat;
  int p0;

  initial begin
    rst = 1'b1; deal = 1'b0; force_en = 1'b0; force_val = 4'd0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_step", rand_step, 0);
    chk_cards("rst", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;

    // Sequence 4, 8, 0(rej), 1, 3
    p0 = pulses;
    deal_and_wait("seq1", lat);
    chk("seq1_lat", lat, 10);
    chk("seq1_pulses", pulses - p0, 5);
    chk("seq1_busy", busy, 0);
    chk_cards("seq1", 4, 8, 1, 3);

    // Sequence 7, 14, 13, 11, 6, 12, 9, 2
    p0 = pulses;
    deal_and_wait("seq2", lat);
    chk("seq2_lat", lat, 16);
    chk("seq2_pulses", pulses - p0, 8);
    chk_cards("seq2", 7, 6, 9, 2);

    force_en = 1'b1;
    force_val = 4'd5;
    deal_and_wait("f5", lat);
    chk("f5_lat", lat, 8);
    chk_cards("f5", 5, 5, 5, 5);

    // All samples out of range: 16 rejections then 4 substitutions
    force_val = 4'd0;
    p0 = pulses;
    deal_and_wait("f0", lat);
    chk("f0_lat", lat, 40);
    chk("f0_pulses", pulses - p0, 20);
    chk_cards("f0", 1, 1, 1, 1);

    // Upper boundary value accepted, held deal plus re-edge while busy
    force_val = 4'd9;
    p0 = pulses;
    @(negedge clk) deal = 1'b0;
    @(negedge clk) deal = 1'b1;
    @(posedge clk);
    @(negedge clk); @(negedge clk) deal = 1'b0;
    @(negedge clk) deal = 1'b1;
    repeat (50) @(posedge clk);
    #1;
    chk("hold_valid", valid, 1);
    chk("hold_busy", busy, 0);
    chk("hold_pulses", pulses - p0, 4);
    chk_cards("hold", 9, 9, 9, 9);

    // Reset mid-deal
    force_val = 4'd5;
    @(negedge clk) deal = 1'b0;
    @(negedge clk) deal = 1'b1;
    @(posedge clk);
    repeat (4) @(posedge clk);
    #1;
    chk("mid_c1", card1, 5);
    @(negedge clk) begin rst = 1'b1; deal = 1'b0; end
    @(posedge clk); #1;
    chk("mrst_valid", valid, 0);
    chk("mrst_busy", busy, 0);
    chk("mrst_step", rand_step, 0);
    chk_cards("mrst", 0, 0, 0, 0);
    @(negedge clk) rst = 1'b0;

    force_val = 4'd3;
    deal_and_wait("fresh", lat);
    chk("fresh_lat", lat, 8);
    chk_cards("fresh", 3, 3, 3, 3);

    chk("no_overlap", overlap, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
